// File: rtl/vc_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vc_sweep_sequencer
// Purpose  : Steps the VC DAC through a start/step/steps sweep, settling and
//            running a number of ADC sample handshakes at every point.
// Revision : 1.0 - initial release
// ============================================================================
module vc_sweep_sequencer #(
   parameter int DACBITS       = 12,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_vcReset,
   input  logic               i_sweepOn,
   input  logic               i_sweepUp,
   input  logic               i_shutdown,
   input  logic [DACBITS-1:0] i_step,
   input  logic [DACBITS-1:0] i_repeats,
   input  logic [DACBITS-1:0] i_start,
   input  logic [DACBITS-1:0] i_steps,
   input  logic               i_sampleDone,
   output logic [DACBITS-1:0] o_dacCode,
   output logic               o_dacLoad,
   output logic               o_sampleReq,
   output logic [DACBITS-1:0] o_pointIndex,
   output logic               o_busy,
   output logic               o_sweepDone
);

   localparam int c_SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_SAMPLE  = 3'd3,
      ST_ADVANCE = 3'd4
   } state_t;

   state_t             r_state, w_state;
   logic [DACBITS-1:0] r_code, w_code;
   logic [DACBITS-1:0] r_index, w_index;
   logic [DACBITS-1:0] r_step, w_step;
   logic [DACBITS-1:0] r_repeats, w_repeats;
   logic [DACBITS-1:0] r_steps, w_steps;
   logic               r_up, w_up;
   logic [c_SW-1:0]    r_settle, w_settle;
   logic [DACBITS-1:0] r_rep, w_rep;
   logic               r_req, w_req;
   logic               r_vcSync1, r_vcSync2, r_vcPrev;

   logic               w_restart;
   logic               w_abort;
   logic               w_last;
   logic [DACBITS-1:0] w_repTarget;
   logic [DACBITS-1:0] w_repNext;
   logic [DACBITS:0]   w_sum;
   logic [DACBITS:0]   w_diff;
   logic [DACBITS-1:0] w_nextCode;

   assign w_restart   = r_vcSync2 & ~r_vcPrev;
   assign w_abort     = i_shutdown | w_restart | ~i_sweepOn;
   assign w_last      = (r_index == (r_steps - DACBITS'(1)));
   assign w_repTarget = (r_repeats == '0) ? DACBITS'(1) : r_repeats;
   assign w_repNext   = r_rep + DACBITS'(1);

   // One extra bit exposes carry/borrow so the code clamps instead of wrapping.
   assign w_sum      = {1'b0, r_code} + {1'b0, r_step};
   assign w_diff     = {1'b0, r_code} - {1'b0, r_step};
   assign w_nextCode = r_up ? (w_sum[DACBITS]  ? '1 : w_sum[DACBITS-1:0])
                            : (w_diff[DACBITS] ? '0 : w_diff[DACBITS-1:0]);

   assign o_busy = (r_state != ST_IDLE);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_code    <= '0;
         r_index   <= '0;
         r_step    <= '0;
         r_repeats <= '0;
         r_steps   <= '0;
         r_up      <= 1'b0;
         r_settle  <= '0;
         r_rep     <= '0;
         r_req     <= 1'b0;
         r_vcSync1 <= 1'b0;
         r_vcSync2 <= 1'b0;
         r_vcPrev  <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_code    <= w_code;
         r_index   <= w_index;
         r_step    <= w_step;
         r_repeats <= w_repeats;
         r_steps   <= w_steps;
         r_up      <= w_up;
         r_settle  <= w_settle;
         r_rep     <= w_rep;
         r_req     <= w_req;
         r_vcSync1 <= i_vcReset;
         r_vcSync2 <= r_vcSync1;
         r_vcPrev  <= r_vcSync2;
      end
   end

   always_comb begin
      w_state      = r_state;
      w_code       = r_code;
      w_index      = r_index;
      w_step       = r_step;
      w_repeats    = r_repeats;
      w_steps      = r_steps;
      w_up         = r_up;
      w_settle     = r_settle;
      w_rep        = r_rep;
      w_req        = r_req;
      o_dacCode    = r_code;
      o_pointIndex = r_index;
      o_dacLoad    = 1'b0;
      o_sampleReq  = 1'b0;
      o_sweepDone  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (i_sweepOn) w_state = ST_LOAD;
         end
         ST_LOAD: begin
            if (!w_abort) begin
               w_step       = i_step;
               w_repeats    = i_repeats;
               w_steps      = i_steps;
               w_up         = i_sweepUp;
               w_code       = i_start;
               w_index      = '0;
               o_dacCode    = i_start;
               o_pointIndex = '0;
               if (i_steps == '0) begin
                  o_sweepDone = 1'b1;
                  w_state     = ST_IDLE;
               end else begin
                  o_dacLoad = 1'b1;
                  w_settle  = '0;
                  w_state   = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (r_settle == c_SETTLE_LAST) begin
               w_req   = 1'b1;
               w_rep   = '0;
               w_state = ST_SAMPLE;
            end else begin
               w_settle = r_settle + c_SW'(1);
            end
         end
         ST_SAMPLE: begin
            o_sampleReq = r_req;
            // Request stays low for one cycle after each ack before re-raising.
            if (!r_req) begin
               w_req = 1'b1;
            end else if (i_sampleDone) begin
               w_req = 1'b0;
               w_rep = w_repNext;
               if (!i_sweepOn)
                  w_state = ST_IDLE;
               else if (w_repNext == w_repTarget)
                  w_state = ST_ADVANCE;
            end
         end
         ST_ADVANCE: begin
            if (!w_abort) begin
               if (w_last) begin
                  o_sweepDone = 1'b1;
                  w_state     = ST_LOAD;
               end else begin
                  w_code       = w_nextCode;
                  w_index      = r_index + DACBITS'(1);
                  o_dacCode    = w_nextCode;
                  o_pointIndex = r_index + DACBITS'(1);
                  o_dacLoad    = 1'b1;
                  w_settle     = '0;
                  w_state      = ST_SETTLE;
               end
            end
         end
         default: w_state = ST_IDLE;
      endcase

      // Priority: shutdown, then restart edge, then sweep enable dropping.
      if (i_shutdown) begin
         w_state = ST_IDLE;
         w_code  = '0;
         w_index = '0;
         w_req   = 1'b0;
      end else if (r_state != ST_IDLE) begin
         if (w_restart) begin
            w_state = i_sweepOn ? ST_LOAD : ST_IDLE;
            w_req   = 1'b0;
         end else if (!i_sweepOn && !(r_state == ST_SAMPLE && r_req)) begin
            w_state = ST_IDLE;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vc_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_sweep_sequencer
// Purpose  : Directed sweeps against hand-computed DAC code sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_sweep_sequencer;

   localparam int DACBITS       = 12;
   localparam int SETTLE_CYCLES = 16;

   logic               i_clk = 1'b0;
   logic               i_rst;
   logic               i_vcReset;
   logic               i_sweepOn;
   logic               i_sweepUp;
   logic               i_shutdown;
   logic [DACBITS-1:0] i_step;
   logic [DACBITS-1:0] i_repeats;
   logic [DACBITS-1:0] i_start;
   logic [DACBITS-1:0] i_steps;
   logic               i_sampleDone;
   logic [DACBITS-1:0] o_dacCode;
   logic               o_dacLoad;
   logic               o_sampleReq;
   logic [DACBITS-1:0] o_pointIndex;
   logic               o_busy;
   logic               o_sweepDone;

   int n_vec = 0;
   int n_err = 0;
   int n_done = 0;
   int n_ack = 0;
   int ack_pulse_req = 0;
   bit ack_en = 1'b1;
   logic [DACBITS-1:0] load_q[$];
   logic [DACBITS-1:0] ack_q[$];

   vc_sweep_sequencer #(
      .DACBITS       (DACBITS),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_vcReset    (i_vcReset),
      .i_sweepOn    (i_sweepOn),
      .i_sweepUp    (i_sweepUp),
      .i_shutdown   (i_shutdown),
      .i_step       (i_step),
      .i_repeats    (i_repeats),
      .i_start      (i_start),
      .i_steps      (i_steps),
      .i_sampleDone (i_sampleDone),
      .o_dacCode    (o_dacCode),
      .o_dacLoad    (o_dacLoad),
      .o_sampleReq  (o_sampleReq),
      .o_pointIndex (o_pointIndex),
      .o_busy       (o_busy),
      .o_sweepDone  (o_sweepDone)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   // ADC model: acks two clocks after it sees a request, or on demand.
   initial begin
      int wait_cnt;
      int pulses_seen;
      wait_cnt = 0;
      pulses_seen = 0;
      i_sampleDone = 1'b0;
      forever begin
         @(posedge i_clk);
         #2;
         if (i_sampleDone) begin
            i_sampleDone = 1'b0;
            wait_cnt = 0;
         end else if (ack_pulse_req != pulses_seen) begin
            pulses_seen = ack_pulse_req;
            i_sampleDone = 1'b1;
         end else if (ack_en && o_sampleReq) begin
            if (wait_cnt >= 1) begin
               i_sampleDone = 1'b1;
               wait_cnt = 0;
               n_ack++;
               ack_q.push_back(o_dacCode);
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge i_clk);
         #3;
         if (o_dacLoad) load_q.push_back(o_dacCode);
         if (o_sweepDone) n_done++;
      end
   end

   // Returns in the relaunch LOAD cycle that follows the first sweepDone.
   task automatic run_sweep(input int budget);
      int base;
      int k;
      base = n_done;
      k = 0;
      i_sweepOn = 1'b1;
      while (n_done == base && k < budget) begin
         tick(1);
         k++;
      end
      chk("sweep_complete", (n_done != base), 1);
   endtask

   task automatic stop_sweep();
      tick(1);
      i_sweepOn = 1'b0;
      tick(2);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int l0;
      int d0;
      int a0;
      int k;
      int cnt;
      int exp_up[4];
      int exp_dn[4];

      i_rst = 1'b1;
      i_vcReset = 1'b0;
      i_sweepOn = 1'b0;
      i_sweepUp = 1'b1;
      i_shutdown = 1'b0;
      i_step = '0;
      i_repeats = '0;
      i_start = '0;
      i_steps = '0;
      tick(3);
      chk("rst_code", o_dacCode, 0);
      chk("rst_load", o_dacLoad, 0);
      chk("rst_req", o_sampleReq, 0);
      chk("rst_index", o_pointIndex, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_sweepDone, 0);
      i_rst = 1'b0;
      tick(2);
      chk("idle_busy", o_busy, 0);

      // Basic up sweep, two samples per point, continuous relaunch.
      i_start = 12'd100; i_step = 12'd4; i_steps = 12'd3; i_repeats = 12'd2; i_sweepUp = 1'b1;
      l0 = load_q.size(); d0 = n_done; a0 = n_ack;
      run_sweep(400);
      chk("t1_relaunch_load", o_dacLoad, 1);
      chk("t1_relaunch_code", o_dacCode, 100);
      chk("t1_relaunch_index", o_pointIndex, 0);
      stop_sweep();
      chk("t1_load_count", load_q.size() - l0, 4);
      for (int i = 0; i < 3; i++) chk("t1_load_code", load_q[l0 + i], 100 + 4 * i);
      chk("t1_ack_count", n_ack - a0, 6);
      for (int i = 0; i < 6; i++) chk("t1_ack_code", ack_q[a0 + i], 100 + 4 * (i / 2));
      chk("t1_done_count", n_done - d0, 1);
      chk("t1_idle", o_busy, 0);
      chk("t1_code_held", o_dacCode, 100);

      // Saturation up, then down.
      exp_up = '{4090, 4094, 4095, 4095};
      exp_dn = '{5, 1, 0, 0};
      i_start = 12'd4090; i_step = 12'd4; i_steps = 12'd4; i_repeats = 12'd1; i_sweepUp = 1'b1;
      l0 = load_q.size(); d0 = n_done;
      run_sweep(600);
      stop_sweep();
      chk("t2_up_done", n_done - d0, 1);
      for (int i = 0; i < 4; i++) chk("t2_up_code", load_q[l0 + i], exp_up[i]);
      i_start = 12'd5; i_sweepUp = 1'b0;
      l0 = load_q.size(); d0 = n_done;
      run_sweep(600);
      stop_sweep();
      chk("t2_dn_done", n_done - d0, 1);
      for (int i = 0; i < 4; i++) chk("t2_dn_code", load_q[l0 + i], exp_dn[i]);

      // Zero points: done straight out of LOAD, no DAC load.
      i_steps = 12'd0; i_start = 12'd77; i_sweepUp = 1'b1;
      i_sweepOn = 1'b1;
      tick(1);
      chk("t3_done_in_load", o_sweepDone, 1);
      chk("t3_no_load", o_dacLoad, 0);
      chk("t3_busy", o_busy, 1);
      i_sweepOn = 1'b0;
      tick(1);
      chk("t3_idle_after", o_busy, 0);
      chk("t3_done_single", o_sweepDone, 0);

      // repeats=0 behaves as one sample per point.
      i_start = 12'd10; i_step = 12'd1; i_steps = 12'd2; i_repeats = 12'd0;
      a0 = n_ack;
      run_sweep(400);
      stop_sweep();
      chk("t3_rep0_acks", n_ack - a0, 2);
      chk("t3_rep0_ack0", ack_q[a0], 10);
      chk("t3_rep0_ack1", ack_q[a0 + 1], 11);

      // Settle latency and a held request.
      i_start = 12'd50; i_step = 12'd1; i_steps = 12'd1; i_repeats = 12'd1;
      ack_en = 1'b0;
      d0 = n_done;
      i_sweepOn = 1'b1;
      k = 0;
      do begin tick(1); k++; end while (o_dacLoad !== 1'b1 && k < 10);
      chk("t4_load_seen", o_dacLoad, 1);
      cnt = 0;
      do begin tick(1); cnt++; end while (o_sampleReq !== 1'b1 && cnt < 40);
      chk("t4_load_to_req", cnt, SETTLE_CYCLES + 1);
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (o_sampleReq === 1'b1) cnt++;
      end
      chk("t4_req_held", cnt, 50);

      // Sweep enable drops with request high: finish handshake, then idle.
      i_sweepOn = 1'b0;
      tick(3);
      chk("t6_wait_ack_busy", o_busy, 1);
      chk("t6_wait_ack_req", o_sampleReq, 1);
      ack_en = 1'b1;
      k = 0;
      do begin tick(1); k++; end while (o_busy !== 1'b0 && k < 10);
      chk("t6_idle_after_ack", o_busy, 0);
      chk("t6_code_held", o_dacCode, 50);
      chk("t6_no_done", n_done - d0, 0);

      // Restart edge mid-SAMPLE on the second point.
      i_start = 12'd200; i_step = 12'd1; i_steps = 12'd3; i_repeats = 12'd1; i_sweepUp = 1'b1;
      i_sweepOn = 1'b1;
      k = 0;
      do begin tick(1); k++; end while (!(o_sampleReq === 1'b1 && o_pointIndex == 12'd1) && k < 100);
      ack_en = 1'b0;
      chk("t5_pre_code", o_dacCode, 201);
      chk("t5_pre_index", o_pointIndex, 1);
      i_vcReset = 1'b1;
      tick(2);
      chk("t5_req_before", o_sampleReq, 1);
      chk("t5_no_early_load", o_dacLoad, 0);
      tick(1);
      chk("t5_req_dropped", o_sampleReq, 0);
      chk("t5_reload", o_dacLoad, 1);
      chk("t5_code", o_dacCode, 200);
      chk("t5_index", o_pointIndex, 0);
      i_vcReset = 1'b0;
      stop_sweep();

      // Shutdown mid-SETTLE; stray ack afterwards is ignored.
      i_start = 12'd300; i_steps = 12'd2;
      d0 = n_done;
      i_sweepOn = 1'b1;
      tick(1);
      chk("t6_load", o_dacLoad, 1);
      tick(5);
      chk("t6_settling", o_busy, 1);
      i_shutdown = 1'b1;
      tick(1);
      chk("t6_sd_code", o_dacCode, 0);
      chk("t6_sd_busy", o_busy, 0);
      chk("t6_sd_req", o_sampleReq, 0);
      ack_pulse_req++;
      tick(3);
      chk("t6_late_ack_busy", o_busy, 0);
      chk("t6_late_ack_code", o_dacCode, 0);
      chk("t6_sd_no_done", n_done - d0, 0);

      // Shutdown with a request outstanding drops it at once.
      i_shutdown = 1'b0;
      k = 0;
      do begin tick(1); k++; end while (o_sampleReq !== 1'b1 && k < 40);
      chk("t6_req_up", o_sampleReq, 1);
      i_shutdown = 1'b1;
      tick(1);
      chk("t6_req_abandon", o_sampleReq, 0);
      chk("t6_req_abandon_busy", o_busy, 0);
      i_shutdown = 1'b0;

      // Asynchronous reset mid-sample.
      k = 0;
      do begin tick(1); k++; end while (o_sampleReq !== 1'b1 && k < 40);
      i_sweepOn = 1'b0;
      #2;
      i_rst = 1'b1;
      #1;
      chk("t7_arst_req", o_sampleReq, 0);
      chk("t7_arst_busy", o_busy, 0);
      chk("t7_arst_code", o_dacCode, 0);
      tick(1);
      i_rst = 1'b0;
      tick(2);
      chk("t7_after_rst", o_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
